key_filter_bank: RTL and testbench

Parametrised, multi-channel successor to the per-key debounce filter used by the vending-machine top level. One instance replaces the row of single-key filters in front of `state_transitions`. It synchronises N mechanical key inputs and debounces them against a shared millisecond tick. Per channel it produces a clean level, press/release pulses, long-press detection and optional auto-repeat. A priority-encoded event port lets the FSM consume one key code per cycle.

---
 rtl/key_filter_bank_if.sv | 14 +
 rtl/key_filter_bank.sv | 106 ++++++++++
 tb/tb_key_filter_bank.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/key_filter_bank_if.sv
// key_filter_bank_if: raw key pins, filtered key outputs and the priority-encoded event port
interface key_filter_bank_if #(parameter int CHANNELS = 16);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  logic [CHANNELS-1:0] key_in;
  logic [CHANNELS-1:0] key_level;
  logic [CHANNELS-1:0] key_press;
  logic [CHANNELS-1:0] key_release;
  logic [CHANNELS-1:0] key_long;
  logic evt_valid;
  logic [IW-1:0] evt_id;
  logic evt_repeat;
  modport master (output key_in, input key_level, key_press, key_release, key_long, evt_valid, evt_id, evt_repeat);
  modport slave (input key_in, output key_level, key_press, key_release, key_long, evt_valid, evt_id, evt_repeat);
endinterface

// File: rtl/key_filter_bank.sv
// key_filter_bank: multi-channel key synchroniser/debouncer with long-press, auto-repeat and event encoder
module key_filter_bank #(
  parameter int CHANNELS = 16,
  parameter int TICK_DIV = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter logic [CHANNELS-1:0] INVERT_MASK = '0,
  parameter logic [CHANNELS-1:0] REPEAT_MASK = '0
) (
  input logic sys_clk,
  input logic sys_rst,
  key_filter_bank_if.slave k
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int HW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} hold_t;
  logic [PW-1:0] pcnt;
  logic tick;
  logic [CHANNELS-1:0] s1, s2, raw_s, stable, long_done;
  logic [CHANNELS-1:0] flip, rise, fall, lng, rpt, prs;
  logic [DW-1:0] dcnt [CHANNELS];
  logic [HW-1:0] hcnt [CHANNELS];
  logic [RW-1:0] rcnt [CHANNELS];
  hold_t st [CHANNELS];
  logic [IW-1:0] id_nx;
  logic rep_nx;
  assign tick = pcnt == PW'(TICK_DIV - 1);
  assign raw_s = s2 ^ INVERT_MASK;
  assign k.key_level = stable;
  // a release on the same tick as a long/repeat compare wins, so no stray pulse follows it
  always_comb begin
    flip = '0;
    rise = '0;
    fall = '0;
    lng = '0;
    rpt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      flip[c] = tick && (raw_s[c] != stable[c]) && (dcnt[c] == DW'(DEBOUNCE_TICKS - 1));
      rise[c] = flip[c] && !stable[c];
      fall[c] = flip[c] && stable[c];
      lng[c] = tick && st[c] == HELD && !long_done[c] && hcnt[c] == HW'(LONG_TICKS - 1) && !fall[c];
      rpt[c] = tick && st[c] == REPEAT && rcnt[c] == RW'(REPEAT_TICKS - 1) && !fall[c];
    end
    prs = rise | rpt;
    id_nx = '0;
    rep_nx = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      id_nx = prs[c] ? IW'(c) : id_nx;
      rep_nx = prs[c] ? rpt[c] : rep_nx;
    end
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pcnt <= '0;
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      long_done <= '0;
      k.key_press <= '0;
      k.key_release <= '0;
      k.key_long <= '0;
      k.evt_valid <= 1'b0;
      k.evt_id <= '0;
      k.evt_repeat <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        dcnt[c] <= '0;
        hcnt[c] <= '0;
        rcnt[c] <= '0;
        st[c] <= IDLE;
      end
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      s1 <= k.key_in;
      s2 <= s1;
      stable <= stable ^ flip;
      for (int c = 0; c < CHANNELS; c++) begin
        dcnt[c] <= (raw_s[c] == stable[c] || flip[c]) ? '0 : tick ? dcnt[c] + 1'b1 : dcnt[c];
        if (flip[c]) begin
          st[c] <= rise[c] ? HELD : IDLE;
          hcnt[c] <= '0;
          rcnt[c] <= '0;
          long_done[c] <= 1'b0;
        end else if (tick && st[c] == HELD && !long_done[c]) begin
          if (lng[c]) begin
            long_done[c] <= 1'b1;
            st[c] <= REPEAT_MASK[c] ? REPEAT : HELD;
          end else begin
            hcnt[c] <= hcnt[c] + 1'b1;
          end
        end else if (tick && st[c] == REPEAT) begin
          rcnt[c] <= rpt[c] ? '0 : rcnt[c] + 1'b1;
        end
      end
      k.key_press <= prs;
      k.key_release <= fall;
      k.key_long <= lng;
      k.evt_valid <= |prs;
      k.evt_id <= id_nx;
      k.evt_repeat <= rep_nx;
    end
  end
endmodule

// File: tb/tb_key_filter_bank.sv
// tb_key_filter_bank: directed vector table plus hand sequences for bounce, simultaneous, inverted and reset cases
module tb_key_filter_bank;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;
  key_filter_bank_if #(.CHANNELS(4)) kif();
  key_filter_bank #(
    .CHANNELS(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .LONG_TICKS(8), .REPEAT_TICKS(4),
    .INVERT_MASK(4'b1000), .REPEAT_MASK(4'b0100)
  ) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .k(kif));
  typedef struct {
    logic [3:0] pins;
    int cyc;
    logic [3:0] lvl;
    logic [15:0] np;
    logic [15:0] nr;
    logic [15:0] nl;
    int nrep;
  } vec_t;
  vec_t tv [7];
  int total = 0;
  int bad = 0;
  logic [15:0] cp, cr, cl;
  int crep;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
    total++;
    if (v < lo || v > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, v, lo, hi);
    end
  endtask
  function automatic logic [31:0] low(input logic [3:0] v);
    logic [31:0] r = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction
  // one clock: sample #1 after the edge, accumulate pulse counts, check the event port
  task automatic step();
    @(posedge sys_clk);
    #1;
    if (!sys_rst) begin
      for (int c = 0; c < 4; c++) begin
        if (kif.key_press[c]) cp[c*4 +: 4] += 4'd1;
        if (kif.key_release[c]) cr[c*4 +: 4] += 4'd1;
        if (kif.key_long[c]) cl[c*4 +: 4] += 4'd1;
      end
      crep += int'(kif.evt_repeat);
      if (kif.key_press != 0 || kif.evt_valid) begin
        chk("evt_valid", kif.evt_valid, |kif.key_press);
        if (|kif.key_press) chk("evt_id", kif.evt_id, low(kif.key_press));
      end
    end
  endtask
  task automatic clr();
    cp = '0;
    cr = '0;
    cl = '0;
    crep = 0;
  endtask
  task automatic wait_press(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (kif.key_press != 0) begin
        n = i;
        break;
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bit found;
    // ch3 pin is active-low, so 4'b1000 means nothing pressed
    tv[0] = '{4'b1000, 30, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0};
    tv[1] = '{4'b1001, 60, 4'b0001, 16'h0001, 16'h0000, 16'h0001, 0};
    tv[2] = '{4'b1000, 30, 4'b0000, 16'h0000, 16'h0001, 16'h0000, 0};
    tv[3] = '{4'b1010, 80, 4'b0010, 16'h0010, 16'h0000, 16'h0010, 0};
    tv[4] = '{4'b1000, 30, 4'b0000, 16'h0000, 16'h0010, 16'h0000, 0};
    tv[5] = '{4'b1100, 78, 4'b0100, 16'h0300, 16'h0000, 16'h0100, 2};
    tv[6] = '{4'b1000, 30, 4'b0000, 16'h0000, 16'h0100, 16'h0000, 0};
    kif.key_in = 4'b1000;
    clr();
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outs", {kif.key_level, kif.key_press, kif.key_release, kif.key_long,
                       kif.evt_valid, kif.evt_id, kif.evt_repeat}, 0);
    sys_rst = 1'b0;
    for (int v = 0; v < 7; v++) begin
      kif.key_in = tv[v].pins;
      clr();
      repeat (tv[v].cyc) step();
      chk($sformatf("v%0d_level", v), kif.key_level, tv[v].lvl);
      chk($sformatf("v%0d_press", v), cp, tv[v].np);
      chk($sformatf("v%0d_release", v), cr, tv[v].nr);
      chk($sformatf("v%0d_long", v), cl, tv[v].nl);
      chk($sformatf("v%0d_repeat", v), crep, tv[v].nrep);
    end
    clr();
    for (int i = 0; i < 14; i++) begin
      kif.key_in = i[0] ? 4'b1000 : 4'b1010;
      repeat (3) step();
    end
    kif.key_in = 4'b1000;
    repeat (30) step();
    chk("bounce_press", cp, 0);
    chk("bounce_release", cr, 0);
    chk("bounce_level", kif.key_level, 0);
    kif.key_in = 4'b1110;
    wait_press(n);
    chk_rng("simul_latency", n, 11, 14);
    chk("simul_press", kif.key_press, 4'b0110);
    chk("simul_evt_id", kif.evt_id, 1);
    chk("simul_evt_repeat", kif.evt_repeat, 0);
    kif.key_in = 4'b1000;
    repeat (30) step();
    chk("simul_released", kif.key_level, 0);
    kif.key_in = 4'b0000;
    wait_press(n);
    chk_rng("inv_latency", n, 11, 14);
    chk("inv_press", kif.key_press, 4'b1000);
    chk("inv_level", kif.key_level, 4'b1000);
    chk("inv_evt_id", kif.evt_id, 3);
    kif.key_in = 4'b1000;
    repeat (30) step();
    chk("inv_released", kif.key_level, 0);
    kif.key_in = 4'b1100;
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      step();
      if (kif.evt_repeat) found = 1'b1;
    end
    chk("rst_repeat_seen", found, 1);
    chk("rst_repeat_id", kif.evt_id, 2);
    sys_rst = 1'b1;
    #1;
    chk("rst_async_outs", {kif.key_level, kif.key_press, kif.key_release, kif.key_long,
                           kif.evt_valid, kif.evt_id, kif.evt_repeat}, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    wait_press(n);
    chk_rng("rst_repress_latency", n, 11, 14);
    chk("rst_repress", kif.key_press, 4'b0100);
    chk("rst_repress_repeat", kif.evt_repeat, 0);
    kif.key_in = 4'b1000;
    repeat (30) step();
    chk("final_level", kif.key_level, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
